// File: rtl/hova_seq_pkg.sv
// hova_seq_pkg: shared state encoding and frame geometry for the Hovalaag sequencer
package hova_seq_pkg;
  typedef enum logic [1:0] {RST_HOLD, RUN, FETCH} state_e;
  localparam int NUM_STAGES = 10;
  localparam int NUM_CHUNKS = 6;
  localparam int CHUNK_W = 6;
  localparam int PC_STAGE = 7;
  localparam int OUT_STAGE = 0;
endpackage

// File: rtl/hova_clk_gen.sv
// hova_clk_gen: slow TT clock with rise/fall pulses and low-side parking under gate
module hova_clk_gen #(
  parameter int HALF_PERIOD = 524288
) (
  input  logic clk12MHz,
  input  logic reset_n,
  input  logic gate_i,
  output logic tt_clk_o,
  output logic rise_o,
  output logic fall_o,
  output logic parked_o
);
  localparam int CW = HALF_PERIOD > 1 ? $clog2(HALF_PERIOD) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic clk_q, clk_d, park_q, park_d, tc;
  // toggle at terminal count; a gated rise holds the counter until the gate lifts, then restarts it
  always_comb begin
    tc = cnt_q == CW'(HALF_PERIOD - 1);
    rise_o = tc && !clk_q && !gate_i && !park_q;
    fall_o = tc && clk_q;
    park_d = tc && !clk_q && gate_i;
    cnt_d = park_d ? cnt_q : (tc ? '0 : cnt_q + 1'b1);
    clk_d = clk_q ^ (rise_o || fall_o);
  end
  // counter, clock and park registers
  always_ff @(posedge clk12MHz) begin
    if (!reset_n) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
      park_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
      park_q <= park_d;
    end
  end
  assign tt_clk_o = clk_q;
  assign parked_o = park_q;
endmodule

// File: rtl/hova_sequencer.sv
// hova_sequencer: fetches instructions and frames them onto the TT core in six 6-bit chunks
module hova_sequencer
  import hova_seq_pkg::*;
#(
  parameter int HALF_PERIOD = 524288,
  parameter int RESET_CLKS = 21
) (
  input  logic        clk12MHz,
  input  logic        reset_n,
  input  logic        run,
  input  logic        step,
  output logic [7:0]  instr_addr,
  output logic        instr_req,
  input  logic [31:0] instr_data,
  input  logic        instr_valid,
  output logic [7:0]  tt_in,
  input  logic [7:0]  tt_out,
  output logic [7:0]  pc,
  output logic [7:0]  out_value,
  output logic        out_valid,
  output logic [3:0]  stage,
  output logic        halted,
  output logic        stalled
);
  localparam int RW = $clog2(RESET_CLKS + 1);
  state_e state_q, state_d;
  logic tt_rst_n_q, tt_rst_n_d, out_valid_q, out_valid_d, req_q, req_d;
  logic sp_q, sp_d, first_q, first_d, pre_q, pre_d;
  logic [CHUNK_W-1:0] chunk_q, chunk_d;
  logic [7:0] pc_q, pc_d, out_q, out_d;
  logic [3:0] stage_q, stage_d;
  logic [RW-1:0] rc_q, rc_d;
  logic [31:0] instr_q, instr_d;
  logic tt_clk, rise, fall, parked, gate, start, done, xfer;
  hova_clk_gen #(.HALF_PERIOD(HALF_PERIOD)) u_clk (
    .clk12MHz(clk12MHz),
    .reset_n(reset_n),
    .gate_i(gate),
    .tt_clk_o(tt_clk),
    .rise_o(rise),
    .fall_o(fall),
    .parked_o(parked)
  );
  // next-state: reset hold, fetch handshake, stage sequencing and per-fall captures
  always_comb begin
    xfer = req_q && instr_valid;
    start = state_q != RST_HOLD && (pre_q || stage_q == 4'(NUM_STAGES - 1));
    done = state_q == RUN || xfer;
    gate = start && !(done && (run || sp_q));
    state_d = state_q;
    tt_rst_n_d = tt_rst_n_q;
    out_valid_d = 1'b0;
    req_d = req_q;
    sp_d = sp_q || (step && !run);
    first_d = first_q;
    pre_d = pre_q;
    chunk_d = chunk_q;
    pc_d = pc_q;
    out_d = out_q;
    stage_d = stage_q;
    rc_d = rc_q;
    instr_d = instr_q;
    if (state_q == RST_HOLD) begin
      if (rise) rc_d = rc_q + 1'b1;
      if (fall && rc_q == RW'(RESET_CLKS)) begin
        tt_rst_n_d = 1'b1;
        state_d = FETCH;
        req_d = 1'b1;
        pre_d = 1'b1;
      end
    end
    if (xfer) begin
      instr_d = instr_data;
      req_d = 1'b0;
      state_d = RUN;
    end
    if (rise && tt_rst_n_q) begin
      stage_d = start ? 4'd0 : stage_q + 4'd1;
      pre_d = start ? 1'b0 : pre_q;
      sp_d = start ? 1'b0 : sp_d;
    end
    if (fall && tt_rst_n_q) begin
      chunk_d = stage_q < 4'(NUM_CHUNKS) ? CHUNK_W'(instr_q >> (CHUNK_W * int'(stage_q))) : '0;
      if (stage_q == 4'(PC_STAGE)) begin
        pc_d = tt_out;
        state_d = FETCH;
        req_d = 1'b1;
      end
      if (stage_q == 4'(OUT_STAGE)) begin
        out_valid_d = !first_q;
        out_d = first_q ? out_q : tt_out;
        first_d = 1'b0;
      end
    end
  end
  // state registers
  always_ff @(posedge clk12MHz) begin
    if (!reset_n) begin
      state_q <= RST_HOLD;
      tt_rst_n_q <= 1'b0;
      out_valid_q <= 1'b0;
      req_q <= 1'b0;
      sp_q <= 1'b0;
      first_q <= 1'b1;
      pre_q <= 1'b0;
      chunk_q <= '0;
      pc_q <= '0;
      out_q <= '0;
      stage_q <= '0;
      rc_q <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      tt_rst_n_q <= tt_rst_n_d;
      out_valid_q <= out_valid_d;
      req_q <= req_d;
      sp_q <= sp_d;
      first_q <= first_d;
      pre_q <= pre_d;
      chunk_q <= chunk_d;
      pc_q <= pc_d;
      out_q <= out_d;
      stage_q <= stage_d;
      rc_q <= rc_d;
      instr_q <= instr_d;
    end
  end
  assign tt_in = {chunk_q[5:1], tt_rst_n_q ? chunk_q[0] : 1'b1, tt_rst_n_q, tt_clk};
  assign instr_addr = pc_q;
  assign instr_req = req_q;
  assign pc = pc_q;
  assign out_value = out_q;
  assign out_valid = out_valid_q;
  assign stage = stage_q;
  assign halted = parked && gate && done;
  assign stalled = parked && gate && !done;
endmodule

// File: tb/tb_hova_sequencer.sv
// tb_hova_sequencer: randomized frame-level checks of the Hovalaag sequencer against a TT-side model
module tb_hova_sequencer;
  localparam int HP = 2;
  localparam int RC = 3;
  logic clk = 0, rst_n = 0, run = 0, step = 0, instr_valid = 0, force_v = 0;
  logic instr_req, out_valid, halted, stalled;
  logic [7:0] instr_addr, tt_in, pc, out_value, tt_out = 0, cap = 0;
  logic [31:0] instr_data = 0, cur = 0;
  logic [3:0] stage;
  logic [31:0] mem [256];
  logic [31:0] fq [$];
  logic [5:0] ec = 0;
  logic [5:0] k6 [6];
  logic lclk = 0, rose = 0, fell = 0, xfer_now = 0, first = 1, ov_exp = 0;
  int checks = 0, errors = 0, lat = 0, wcnt = 0, rcount = 0, s = 0, pop_err = 0;

  hova_sequencer #(.HALF_PERIOD(HP), .RESET_CLKS(RC)) dut (
    .clk12MHz(clk), .reset_n(rst_n), .run(run), .step(step),
    .instr_addr(instr_addr), .instr_req(instr_req), .instr_data(instr_data), .instr_valid(instr_valid),
    .tt_in(tt_in), .tt_out(tt_out), .pc(pc), .out_value(out_value), .out_valid(out_valid),
    .stage(stage), .halted(halted), .stalled(stalled)
  );

  always #5 clk = ~clk;

  // one system cycle: record the transfer at the coming edge, sample after it, update the model, drive inputs
  task automatic cyc();
    xfer_now = 0;
    if (!rst_n) begin
      fq.delete();
      first = 1;
    end else if (instr_req && instr_valid) begin
      fq.push_back(instr_data);
      xfer_now = 1;
    end
    @(negedge clk);
    step = 0;
    cap = tt_out;
    rose = !lclk && tt_in[0];
    fell = lclk && !tt_in[0];
    lclk = tt_in[0];
    if (!tt_in[1]) rcount = 0;
    else if (rose) begin
      rcount++;
      if ((rcount - 1) % 10 == 0) begin
        if (fq.size() == 0) pop_err++;
        else cur = fq.pop_front();
      end
    end
    s = rcount > 0 ? (rcount - 1) % 10 : 0;
    ec = s < 6 ? 6'(cur >> (6 * s)) : 6'd0;
    ov_exp = fell && rcount > 0 && s == 0 && !first;
    if (fell && rcount > 0 && s == 0) first = 0;
    tt_out = 8'($urandom);
    instr_valid = force_v || (instr_req && wcnt >= lat);
    instr_data = mem[instr_addr];
    wcnt = instr_req ? wcnt + 1 : 0;
  endtask

  task automatic test_reset();
    int r = 0, bad = 0;
    rst_n = 0;
    repeat (3) cyc();
    checks++;
    if ({tt_in, pc, out_value, out_valid, stage, instr_req, halted, stalled} !== 32'h0400_0000) begin
      errors++;
      $display("FAIL reset_values got %h want %h", {tt_in, pc, out_value, out_valid, stage, instr_req, halted, stalled}, 32'h0400_0000);
    end
    rst_n = 1;
    for (int n = 0; n < 200 && !tt_in[1]; n++) begin
      cyc();
      if (rose) r++;
      if (!tt_in[1] && !tt_in[2]) bad++;
    end
    checks++;
    if (r != RC || bad != 0 || tt_in[1] !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold got rises=%0d bad=%0d rst_n=%b want rises=%0d bad=0 rst_n=1", r, bad, tt_in[1], RC);
    end
    checks++;
    if ({instr_req, instr_addr} !== 9'h100) begin
      errors++;
      $display("FAIL first_fetch got req=%b addr=%h want req=1 addr=00", instr_req, instr_addr);
    end
    for (int n = 0; n < 100 && !halted; n++) cyc();
    checks++;
    if ({halted, stalled, stage, tt_in[0]} !== 7'b1000000) begin
      errors++;
      $display("FAIL initial_halt got halted=%b stalled=%b stage=%0d clk=%b want 1 0 0 0", halted, stalled, stage, tt_in[0]);
    end
  endtask

  task automatic test_frames();
    run = 1;
    for (int n = 0; n < 2000 && rcount < 41; n++) begin
      cyc();
      if (fell && rcount > 0) begin
        checks++;
        if (tt_in[7:2] !== ec) begin
          errors++;
          $display("FAIL chunk s=%0d got %h want %h", s, tt_in[7:2], ec);
        end
        checks++;
        if (stage !== 4'(s)) begin
          errors++;
          $display("FAIL stage got %0d want %0d", stage, s);
        end
        if (rcount <= 10 && s < 6) begin
          checks++;
          if (tt_in[7:2] !== k6[s]) begin
            errors++;
            $display("FAIL known_chunk s=%0d got %h want %h", s, tt_in[7:2], k6[s]);
          end
        end
        if (s == 7) begin
          checks++;
          if ({pc, instr_addr, instr_req} !== {cap, cap, 1'b1}) begin
            errors++;
            $display("FAIL pc_capture got pc=%h addr=%h req=%b want %h %h 1", pc, instr_addr, instr_req, cap, cap);
          end
        end
        if (s == 0 && ov_exp) begin
          checks++;
          if (out_value !== cap) begin
            errors++;
            $display("FAIL out_value got %h want %h", out_value, cap);
          end
        end
      end
      checks++;
      if (out_valid !== ov_exp) begin
        errors++;
        $display("FAIL out_valid got %b want %b", out_valid, ov_exp);
      end
    end
    checks++;
    if (rcount < 41 || pop_err != 0) begin
      errors++;
      $display("FAIL frame_progress got rises=%0d pop_err=%0d want 41 0", rcount, pop_err);
    end
  endtask

  task automatic test_stall();
    int bad = 0, d = 0;
    lat = 32;
    for (int n = 0; n < 300 && !stalled; n++) cyc();
    checks++;
    if (stalled !== 1'b1 || stage !== 4'd9) begin
      errors++;
      $display("FAIL stall_enter got stalled=%b stage=%0d want 1 9", stalled, stage);
    end
    for (int n = 0; n < 200 && !xfer_now; n++) begin
      cyc();
      if (!xfer_now && (tt_in[0] || rose || !stalled || halted)) bad++;
    end
    checks++;
    if (bad != 0 || !xfer_now || stalled !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold got bad=%0d xfer=%b stalled=%b want 0 1 0", bad, xfer_now, stalled);
    end
    for (int n = 0; n < 20 && !rose; n++) begin
      cyc();
      d++;
    end
    checks++;
    if (d != HP || !rose || stage !== 4'd0) begin
      errors++;
      $display("FAIL stall_release got delay=%0d rose=%b stage=%0d want %0d 1 0", d, rose, stage, HP);
    end
    lat = 0;
  endtask

  task automatic test_step();
    int r = 0, v = 0;
    step = 1;
    cyc();
    repeat (5) cyc();
    run = 0;
    for (int n = 0; n < 400 && !halted; n++) cyc();
    checks++;
    if ({halted, stage, tt_in[0]} !== 6'b110010) begin
      errors++;
      $display("FAIL halt_after_run got halted=%b stage=%0d clk=%b want 1 9 0", halted, stage, tt_in[0]);
    end
    repeat (40) begin
      cyc();
      if (rose) r++;
    end
    checks++;
    if (r != 0 || halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_stays got rises=%0d halted=%b want 0 1", r, halted);
    end
    for (int k = 0; k < 2; k++) begin
      r = 0;
      v = 0;
      step = 1;
      cyc();
      for (int n = 0; n < 400 && !halted; n++) begin
        cyc();
        if (rose) r++;
        if (out_valid) v++;
      end
      checks++;
      if (r != 10 || v != 1 || halted !== 1'b1 || stage !== 4'd9) begin
        errors++;
        $display("FAIL single_step%0d got rises=%0d outs=%0d halted=%b stage=%0d want 10 1 1 9", k, r, v, halted, stage);
      end
    end
  endtask

  task automatic test_reset_mid();
    int r = 0, bad = 0;
    run = 1;
    for (int n = 0; n < 400 && !(stage == 4'd4 && tt_in[1]); n++) cyc();
    rst_n = 0;
    cyc();
    checks++;
    if ({tt_in, pc, out_value, out_valid, stage, instr_req, halted, stalled} !== 32'h0400_0000) begin
      errors++;
      $display("FAIL reset_mid_frame got %h want %h", {tt_in, pc, out_value, out_valid, stage, instr_req, halted, stalled}, 32'h0400_0000);
    end
    rst_n = 1;
    lat = 1000;
    for (int n = 0; n < 400 && !stalled; n++) cyc();
    checks++;
    if (stalled !== 1'b1 || instr_req !== 1'b1) begin
      errors++;
      $display("FAIL pending_fetch got stalled=%b req=%b want 1 1", stalled, instr_req);
    end
    rst_n = 0;
    force_v = 1;
    cyc();
    checks++;
    if ({tt_in, pc, out_value, out_valid, stage, instr_req, halted, stalled} !== 32'h0400_0000) begin
      errors++;
      $display("FAIL reset_mid_fetch got %h want %h", {tt_in, pc, out_value, out_valid, stage, instr_req, halted, stalled}, 32'h0400_0000);
    end
    rst_n = 1;
    for (int n = 0; n < 200 && !tt_in[1]; n++) begin
      cyc();
      if (rose) r++;
      if (!tt_in[1] && instr_req) bad++;
    end
    force_v = 0;
    lat = 0;
    checks++;
    if (r != RC || bad != 0 || {instr_req, instr_addr} !== 9'h100) begin
      errors++;
      $display("FAIL late_valid got rises=%0d bad=%0d req=%b addr=%h want %0d 0 1 00", r, bad, instr_req, instr_addr, RC);
    end
    bad = 0;
    for (int n = 0; n < 400 && rcount < 11; n++) begin
      cyc();
      if (out_valid) bad++;
    end
    checks++;
    if (bad != 0 || rcount < 11) begin
      errors++;
      $display("FAIL first_frame_quiet got outs=%0d rises=%0d want 0 11", bad, rcount);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h8C0A5F13;
    k6 = '{6'h13, 6'h3C, 6'h25, 6'h02, 6'h0C, 6'h02};
    test_reset();
    test_frames();
    test_stall();
    test_step();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
